// File: rtl/uart_defs.sv
// uart_defs: definitions shared by the UART transmitter and the UART receivers.
//   - FSM state encodings (IDLE, START, DATA, PARITY, STOP)
//   - UART_DATA_BITS: payload bits per frame
//   - UART_CLKS_PER_BIT: default bit period (100 MHz / 115200), shared so that
//     both ends of the link agree on the baud rate.
package uart_defs;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 868;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period timer.
//   A free-running counter 0..CLKS_PER_BIT-1 that emits a one-cycle tick while
//   it holds CLKS_PER_BIT-1, then wraps. Holding restart_i keeps it at zero so
//   the first period after restart is exactly CLKS_PER_BIT cycles long.
// Ports:
//   clk        in  system clock
//   rst        in  synchronous active-high reset
//   restart_i  in  clear the counter (next value 0)
//   tick_o     out high on the last cycle of each bit period
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic tick_o
);

  localparam int            CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;

  assign tick_o = (baud_cnt_q == CNT_LAST);

  always_comb begin
    baud_cnt_d = baud_cnt_q + 1'b1;
    if (restart_i || tick_o) begin
      baud_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt_q <= '0;
    end else begin
      baud_cnt_q <= baud_cnt_d;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 UART serializer (8E1 when UART_TX_PARITY_EN is defined).
//   Accepts one byte per valid/ready handshake and shifts it out LSB first,
//   each bit held exactly CLKS_PER_BIT cycles. The serial line is registered.
// Handshake: a byte transfers on a rising edge where tx_valid & tx_ready.
//   tx_ready depends only on the FSM state and rst, never on tx_valid; while a
//   frame is in flight tx_ready is low and the producer must hold its byte.
// Configuration macro: UART_TX_PARITY_EN adds an even-parity bit after DATA.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset (abandons any frame)
//   tx_data    in   byte to send, sampled only on handshake
//   tx_valid   in   producer has a byte on tx_data
//   tx_ready   out  transmitter can accept a byte
//   tx_busy    out  frame in progress (state != IDLE)
//   uart_out   out  serial line, idle high
//   dbg_state  out  current FSM state, for observation only
module uart_transmitter
  import uart_defs::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       uart_out,
  output logic [2:0] dbg_state
);

  localparam logic [2:0] BIT_LAST = 3'(UART_DATA_BITS - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       uart_out_q, uart_out_d;
  logic       tick;
  logic       handshake;
`ifdef UART_TX_PARITY_EN
  logic       parity_q, parity_d;
`endif

  // The timer is held at zero while idle, so the START bit is timed from the
  // handshake edge.
  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .restart_i(state_q == ST_IDLE),
    .tick_o   (tick)
  );

  assign tx_ready  = (state_q == ST_IDLE) && !rst;
  assign tx_busy   = (state_q != ST_IDLE);
  assign uart_out  = uart_out_q;
  assign dbg_state = state_q;
  assign handshake = tx_valid && tx_ready;

  // uart_out_d is the line value for the state being entered, so the
  // registered output lines up with the state register.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    uart_out_d = uart_out_q;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        uart_out_d = 1'b1;
        if (handshake) begin
          state_d    = ST_START;
          shift_d    = tx_data;
          bit_idx_d  = '0;
          uart_out_d = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d   = ^tx_data;
`endif
        end
      end
      ST_START: begin
        if (tick) begin
          state_d    = ST_DATA;
          uart_out_d = shift_q[0];
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_idx_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d    = ST_PARITY;
            uart_out_d = parity_q;
`else
            state_d    = ST_STOP;
            uart_out_d = 1'b1;
`endif
          end else begin
            shift_d    = {1'b0, shift_q[7:1]};
            bit_idx_d  = bit_idx_q + 1'b1;
            uart_out_d = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          state_d    = ST_STOP;
          uart_out_d = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          state_d    = ST_IDLE;
          uart_out_d = 1'b1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        uart_out_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      uart_out_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      uart_out_q <= uart_out_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter with CLKS_PER_BIT=4.
// Inputs are driven 1 time unit after a rising edge; outputs are sampled at
// that same point, away from the active edge.
module tb_uart_transmitter;
  import uart_defs::*;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_busy;
  logic       uart_out;
  logic [2:0] dbg_state;

  int total = 0;
  int bad   = 0;

  uart_transmitter #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_busy  (tx_busy),
    .uart_out (uart_out),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Steps until a handshake edge has just occurred (bounded).
  task automatic wait_accept(input string tag);
    int n;
    n = 0;
    while (!(tx_ready && tx_valid) && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
    end
    step();
  endtask

  // Checks a whole frame, starting the cycle after the handshake edge.
  // At cycle 5 the inputs are changed to mid_valid/mid_data.
  task automatic check_frame(input string tag, input logic [7:0] d,
                             input logic mid_valid, input logic [7:0] mid_data);
    logic [10:0] bits;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
`ifdef UART_TX_PARITY_EN
    bits[9] = ^d;
`endif
    for (int i = 0; i < NBITS * CPB; i++) begin
      chk({tag, "_line"}, 32'(uart_out), 32'(bits[i / CPB]));
      chk({tag, "_busy"}, 32'(tx_busy), 32'd1);
      chk({tag, "_ready"}, 32'(tx_ready), 32'd0);
      if (i == 5) begin
        tx_valid = mid_valid;
        tx_data  = mid_data;
      end
      step();
    end
    // idle cycle after STOP
    chk({tag, "_idle_line"}, 32'(uart_out), 32'd1);
    chk({tag, "_idle_busy"}, 32'(tx_busy), 32'd0);
    chk({tag, "_idle_ready"}, 32'(tx_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    tx_valid = 1'b0;
    tx_data = 8'h00;

    // reset held 3 cycles
    for (int i = 0; i < 3; i++) step();
    chk("rst_line", 32'(uart_out), 32'd1);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_ready", 32'(tx_ready), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    step();
    chk("rel_ready", 32'(tx_ready), 32'd1);
    chk("rel_line", 32'(uart_out), 32'd1);

    // 0x61: line 0,1,0,0,0,0,1,1,0,1
    tx_data = 8'h61;
    tx_valid = 1'b1;
    wait_accept("a");
    tx_valid = 1'b0;
    check_frame("a", 8'h61, 1'b0, 8'h61);
    step();
    chk("a_stay_idle", 32'(tx_busy), 32'd0);

    // back-to-back: 0x55 then 0xAA with tx_valid held high
    tx_data = 8'h55;
    tx_valid = 1'b1;
    wait_accept("b2b0");
    check_frame("b2b0", 8'h55, 1'b1, 8'hAA);
    // idle cycle checked above; handshake for 0xAA happens at this edge
    step();
    check_frame("b2b1", 8'hAA, 1'b0, 8'hAA);
    step();

    // reset at cycle 17 of a 0xFF frame
    tx_data = 8'hFF;
    tx_valid = 1'b1;
    wait_accept("rstmid");
    tx_valid = 1'b0;
    chk("rstmid_start", 32'(uart_out), 32'd0);
    for (int i = 0; i < 17; i++) step();
    chk("rstmid_busy_before", 32'(tx_busy), 32'd1);
    rst = 1'b1;
    step();
    chk("rstmid_line", 32'(uart_out), 32'd1);
    chk("rstmid_busy", 32'(tx_busy), 32'd0);
    chk("rstmid_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rstmid_ready", 32'(tx_ready), 32'd0);
    rst = 1'b0;
    step();
    tx_data = 8'h00;
    tx_valid = 1'b1;
    wait_accept("zero");
    tx_valid = 1'b0;
    check_frame("zero", 8'h00, 1'b0, 8'h00);
    step();

    // tx_data changes mid-frame: only 0x0F goes out
    tx_data = 8'h0F;
    tx_valid = 1'b1;
    wait_accept("midchg");
    tx_valid = 1'b0;
    check_frame("midchg", 8'h0F, 1'b0, 8'hF0);
    step();

`ifdef UART_TX_PARITY_EN
    // parity of 0x07 is 1, of 0x03 is 0
    tx_data = 8'h07;
    tx_valid = 1'b1;
    wait_accept("par07");
    tx_valid = 1'b0;
    check_frame("par07", 8'h07, 1'b0, 8'h07);
    step();
    tx_data = 8'h03;
    tx_valid = 1'b1;
    wait_accept("par03");
    tx_valid = 1'b0;
    check_frame("par03", 8'h03, 1'b0, 8'h03);
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
